// File: rtl/shift_rows_pipe.sv
// Two-stage pipelined ShiftRows / InvShiftRows / bypass for a Rijndael state
// of NB columns, with valid/ready backpressure and a pass-through tag.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:32*NB-1]  in_data,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              mode_err,
  output logic              busy
);

  localparam int SW = 32*NB;
  localparam int RB = 8*NB;   // bits per row

  localparam logic [1:0] MODE_BYP = 2'b00;
  localparam logic [1:0] MODE_FWD = 2'b01;
  localparam logic [1:0] MODE_INV = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // vldPipe[1] = S1 holds a state, vldPipe[2] = S2 holds a state
  logic [2:1]       vldPipe;
  logic [0:SW-1]    s1Data, s2Data;
  logic [0:SW-1]    fwdData, invData, permData;
  logic [1:0]       s1Mode;
  logic [TAG_W-1:0] s1Tag, s2Tag;
  logic             modeErr;
  logic             accept, s2Load;

  // S1 can take a new state whenever something downstream of it frees up
  assign in_ready = !vldPipe[1] | !vldPipe[2] | out_ready;
  assign accept   = in_valid & in_ready;
  assign s2Load   = vldPipe[1] & (!vldPipe[2] | out_ready);

  // Static byte routing; NB=8 uses the wider offsets 0,1,3,4
  for (genvar r = 0; r < 4; r++) begin : gRow
    localparam int OFS = (NB == 8 && r >= 2) ? r + 1 : r;
    for (genvar c = 0; c < NB; c++) begin : gCol
      localparam int FSRC = (c + OFS) % NB;
      localparam int ISRC = (c + NB - OFS) % NB;
      assign fwdData[r*RB + 8*c +: 8] = s1Data[r*RB + 8*FSRC +: 8];
      assign invData[r*RB + 8*c +: 8] = s1Data[r*RB + 8*ISRC +: 8];
    end
  end

  // Select permutation by the mode captured with the state; reserved bypasses
  always_comb begin
    permData = s1Data;
    case (s1Mode)
      MODE_FWD: permData = fwdData;
      MODE_INV: permData = invData;
      default:  permData = s1Data;
    endcase
  end

  // Stage occupancy: S1 refills on accept, S2 drains on out_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vldPipe <= '0;
    end else begin
      if (accept)      vldPipe[1] <= 1'b1;
      else if (s2Load) vldPipe[1] <= 1'b0;
      if (s2Load)         vldPipe[2] <= 1'b1;
      else if (out_ready) vldPipe[2] <= 1'b0;
    end
  end

  // S1 captures the raw transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Data <= '0;
      s1Mode <= MODE_BYP;
      s1Tag  <= '0;
    end else if (accept) begin
      s1Data <= in_data;
      s1Mode <= in_mode;
      s1Tag  <= in_tag;
    end
  end

  // S2 holds the permuted result; held while stalled or empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2Data <= '0;
      s2Tag  <= '0;
    end else if (s2Load) begin
      s2Data <= permData;
      s2Tag  <= s1Tag;
    end
  end

  // Sticky flag for an accepted reserved mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              modeErr <= 1'b0;
    else if (accept && in_mode == MODE_RSV) modeErr <= 1'b1;
  end

  assign out_valid = vldPipe[2];
  assign out_data  = s2Data;
  assign out_tag   = s2Tag;
  assign mode_err  = modeErr;
  assign busy      = |vldPipe;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe at NB=4, 6 and 8.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;
  int outCount4 = 0;

  // NB=4 instance
  logic inValid4 = 0, inReady4, outValid4, outReady4 = 0, modeErr4, busy4;
  logic [0:127] inData4 = '0, outData4;
  logic [1:0] inMode4 = 0;
  logic [3:0] inTag4 = 0, outTag4;
  // NB=6 instance
  logic inValid6 = 0, inReady6, outValid6, outReady6 = 1, modeErr6, busy6;
  logic [0:191] inData6 = '0, outData6;
  logic [1:0] inMode6 = 0;
  logic [3:0] inTag6 = 0, outTag6;
  // NB=8 instance
  logic inValid8 = 0, inReady8, outValid8, outReady8 = 1, modeErr8, busy8;
  logic [0:255] inData8 = '0, outData8;
  logic [1:0] inMode8 = 0;
  logic [3:0] inTag8 = 0, outTag8;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(inValid4), .in_ready(inReady4),
    .in_data(inData4), .in_mode(inMode4), .in_tag(inTag4),
    .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
    .out_tag(outTag4), .mode_err(modeErr4), .busy(busy4));

  shift_rows_pipe #(.NB(6), .TAG_W(4)) u6 (
    .clk(clk), .reset(reset), .in_valid(inValid6), .in_ready(inReady6),
    .in_data(inData6), .in_mode(inMode6), .in_tag(inTag6),
    .out_valid(outValid6), .out_ready(outReady6), .out_data(outData6),
    .out_tag(outTag6), .mode_err(modeErr6), .busy(busy6));

  shift_rows_pipe #(.NB(8), .TAG_W(4)) u8 (
    .clk(clk), .reset(reset), .in_valid(inValid8), .in_ready(inReady8),
    .in_data(inData8), .in_mode(inMode8), .in_tag(inTag8),
    .out_valid(outValid8), .out_ready(outReady8), .out_data(outData8),
    .out_tag(outTag8), .mode_err(modeErr8), .busy(busy8));

  typedef struct packed { logic [0:127] d; logic [3:0] t; } exp4T;
  typedef struct packed { logic [0:191] d; logic [3:0] t; } exp6T;
  typedef struct packed { logic [0:255] d; logic [3:0] t; } exp8T;
  exp4T q4[$];
  exp6T q6[$];
  exp8T q8[$];
  exp4T e4;
  exp6T e6;
  exp8T e8;

  // Reference permutation on a row-major state padded to 256 bits
  function automatic logic [0:255] shiftModel(int nb, logic [1:0] mode, logic [0:255] din);
    logic [0:255] res;
    int s, src;
    res = din;
    for (int row = 0; row < 4; row++) begin
      s = (nb == 8 && row >= 2) ? row + 1 : row;
      for (int c = 0; c < nb; c++) begin
        if (mode == 2'b01)      src = (c + s) % nb;
        else if (mode == 2'b10) src = (c - s + nb) % nb;
        else                    src = c;
        res[(row*nb + c)*8 +: 8] = din[(row*nb + src)*8 +: 8];
      end
    end
    return res;
  endfunction

  // Output monitors pop the scoreboards on every handshake
  always @(negedge clk) begin
    if (!reset && outValid4 && outReady4) begin
      nVec++;
      outCount4++;
      if (q4.size() == 0) begin
        nErr++;
        $display("FAIL mon4 unexpected output data=%h tag=%0d, expected no output", outData4, outTag4);
      end else begin
        e4 = q4.pop_front();
        if (outData4 !== e4.d || outTag4 !== e4.t) begin
          nErr++;
          $display("FAIL mon4 got data=%h tag=%0d, expected data=%h tag=%0d", outData4, outTag4, e4.d, e4.t);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && outValid6 && outReady6) begin
      nVec++;
      if (q6.size() == 0) begin
        nErr++;
        $display("FAIL mon6 unexpected output data=%h, expected no output", outData6);
      end else begin
        e6 = q6.pop_front();
        if (outData6 !== e6.d || outTag6 !== e6.t) begin
          nErr++;
          $display("FAIL mon6 got data=%h tag=%0d, expected data=%h tag=%0d", outData6, outTag6, e6.d, e6.t);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && outValid8 && outReady8) begin
      nVec++;
      if (q8.size() == 0) begin
        nErr++;
        $display("FAIL mon8 unexpected output data=%h, expected no output", outData8);
      end else begin
        e8 = q8.pop_front();
        if (outData8 !== e8.d || outTag8 !== e8.t) begin
          nErr++;
          $display("FAIL mon8 got data=%h tag=%0d, expected data=%h tag=%0d", outData8, outTag8, e8.d, e8.t);
        end
      end
    end
  end

  task automatic stepClk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    nVec++;
    if (outValid4 !== 1'b0 || busy4 !== 1'b0 || modeErr4 !== 1'b0 || outData4 !== '0 || outTag4 !== 4'd0) begin
      nErr++;
      $display("FAIL reset_state got valid=%b busy=%b err=%b data=%h tag=%0d, expected all zero",
               outValid4, busy4, modeErr4, outData4, outTag4);
    end
    nVec++;
    if (outValid6 !== 1'b0 || outValid8 !== 1'b0 || busy6 !== 1'b0 || busy8 !== 1'b0) begin
      nErr++;
      $display("FAIL reset_state_nb68 got valid6=%b valid8=%b busy6=%b busy8=%b, expected 0",
               outValid6, outValid8, busy6, busy8);
    end
    @(negedge clk);
    reset = 1'b0;
    stepClk();
  endtask

  task automatic test_inverse;
    logic [0:127] d;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(k);
    inData4 = d; inMode4 = 2'b10; inTag4 = 4'h5; inValid4 = 1'b1; outReady4 = 1'b1;
    e4.d = 128'h00010203_07040506_0A0B0809_0D0E0F0C; e4.t = 4'h5;
    q4.push_back(e4);
    stepClk();
    inValid4 = 1'b0;
    @(negedge clk);
    nVec++;
    if (outValid4 !== 1'b0) begin
      nErr++;
      $display("FAIL inv_latency_early out_valid=%b one cycle after accept, expected 0", outValid4);
    end
    stepClk();
    @(negedge clk);
    nVec++;
    if (outValid4 !== 1'b1 || outTag4 !== 4'h5) begin
      nErr++;
      $display("FAIL inv_latency out_valid=%b tag=%0d two cycles after accept, expected 1 tag=5", outValid4, outTag4);
    end
    nVec++;
    if (modeErr4 !== 1'b0) begin
      nErr++;
      $display("FAIL inv_mode_err got %b, expected 0", modeErr4);
    end
    stepClk();
    @(negedge clk);
    nVec++;
    if (outValid4 !== 1'b0) begin
      nErr++;
      $display("FAIL inv_drain out_valid=%b, expected 0", outValid4);
    end
    stepClk();
  endtask

  task automatic test_back_to_back;
    logic [0:127] d, f;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(k);
    f = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
    outReady4 = 1'b1;
    inValid4 = 1'b1; inData4 = d; inMode4 = 2'b01; inTag4 = 4'd1;
    e4.d = f; e4.t = 4'd1; q4.push_back(e4);
    stepClk();
    inData4 = f; inMode4 = 2'b10; inTag4 = 4'd2;
    e4.d = d; e4.t = 4'd2; q4.push_back(e4);
    stepClk();
    inValid4 = 1'b0;
    @(negedge clk);
    nVec++;
    if (outValid4 !== 1'b1 || outTag4 !== 4'd1) begin
      nErr++;
      $display("FAIL b2b_first out_valid=%b tag=%0d, expected 1 tag=1", outValid4, outTag4);
    end
    stepClk();
    @(negedge clk);
    nVec++;
    if (outValid4 !== 1'b1 || outTag4 !== 4'd2) begin
      nErr++;
      $display("FAIL b2b_second out_valid=%b tag=%0d, expected 1 tag=2", outValid4, outTag4);
    end
    stepClk();
    @(negedge clk);
    nVec++;
    if (outValid4 !== 1'b0 || busy4 !== 1'b0) begin
      nErr++;
      $display("FAIL b2b_drain out_valid=%b busy=%b, expected 0 0", outValid4, busy4);
    end
    stepClk();
  endtask

  task automatic test_nb8_forward;
    logic [0:255] d;
    logic [63:0] row2, row3;
    for (int k = 0; k < 32; k++) d[k*8 +: 8] = 8'(k);
    inValid8 = 1'b1; inData8 = d; inMode8 = 2'b01; inTag8 = 4'd7;
    e8.d = shiftModel(8, 2'b01, d); e8.t = 4'd7; q8.push_back(e8);
    stepClk();
    inValid8 = 1'b0;
    stepClk();
    @(negedge clk);
    row2 = outData8[128 +: 64];
    row3 = outData8[192 +: 64];
    nVec++;
    if (outValid8 !== 1'b1 || row2 !== 64'h13141516_17101112) begin
      nErr++;
      $display("FAIL nb8_row2 valid=%b row=%h, expected 1 1314151617101112", outValid8, row2);
    end
    nVec++;
    if (row3 !== 64'h1C1D1E1F_18191A1B) begin
      nErr++;
      $display("FAIL nb8_row3 row=%h, expected 1c1d1e1f18191a1b", row3);
    end
    stepClk();
  endtask

  task automatic test_backpressure;
    int sent, cyc, start;
    logic acc;
    logic [0:127] stable;
    logic [0:255] m;
    sent = 0; cyc = 0; start = outCount4; stable = '0;
    while ((sent < 5 || q4.size() != 0) && cyc < 60) begin
      outReady4 = (cyc >= 4);
      if (sent < 5) begin
        inValid4 = 1'b1;
        inData4 = {$urandom(), $urandom(), $urandom(), $urandom()};
        inMode4 = 2'($urandom_range(0, 2));
        inTag4 = 4'(8 + sent);
      end else begin
        inValid4 = 1'b0;
      end
      @(negedge clk);
      acc = inValid4 & inReady4;
      if (acc) begin
        m = shiftModel(4, inMode4, {inData4, 128'b0});
        e4.d = m[0:127]; e4.t = inTag4;
        q4.push_back(e4);
      end
      if (cyc == 2) begin
        nVec++;
        if (inReady4 !== 1'b0 || outValid4 !== 1'b1) begin
          nErr++;
          $display("FAIL bp_full in_ready=%b out_valid=%b after 2 accepts, expected 0 1", inReady4, outValid4);
        end
        stable = outData4;
      end
      if (cyc == 3) begin
        nVec++;
        if (inReady4 !== 1'b0 || outValid4 !== 1'b1 || outData4 !== stable) begin
          nErr++;
          $display("FAIL bp_stall in_ready=%b valid=%b data=%h, expected 0 1 %h", inReady4, outValid4, outData4, stable);
        end
      end
      stepClk();
      if (acc) sent++;
      cyc++;
    end
    inValid4 = 1'b0;
    nVec++;
    if (sent != 5 || q4.size() != 0 || outCount4 - start != 5) begin
      nErr++;
      $display("FAIL bp_drain accepted=%0d pending=%0d emitted=%0d, expected 5 0 5",
               sent, q4.size(), outCount4 - start);
    end
  endtask

  task automatic test_reserved_mode;
    logic [0:191] d;
    logic [0:255] m;
    d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    inValid6 = 1'b1; inData6 = d; inMode6 = 2'b11; inTag6 = 4'd9;
    e6.d = d; e6.t = 4'd9; q6.push_back(e6);
    stepClk();
    inValid6 = 1'b0;
    stepClk();
    @(negedge clk);
    nVec++;
    if (modeErr6 !== 1'b1 || outValid6 !== 1'b1) begin
      nErr++;
      $display("FAIL rsv_flag mode_err=%b out_valid=%b, expected 1 1", modeErr6, outValid6);
    end
    stepClk();
    d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    inValid6 = 1'b1; inData6 = d; inMode6 = 2'b01; inTag6 = 4'd10;
    m = shiftModel(6, 2'b01, {d, 64'b0});
    e6.d = m[0:191]; e6.t = 4'd10; q6.push_back(e6);
    stepClk();
    inValid6 = 1'b0;
    stepClk();
    @(negedge clk);
    nVec++;
    if (modeErr6 !== 1'b1 || outValid6 !== 1'b1) begin
      nErr++;
      $display("FAIL rsv_sticky mode_err=%b out_valid=%b, expected 1 1", modeErr6, outValid6);
    end
    stepClk();
  endtask

  task automatic test_reset_midflight;
    logic [0:127] d;
    logic [0:255] m;
    outReady4 = 1'b0;
    inValid4 = 1'b1; inData4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    inMode4 = 2'b01; inTag4 = 4'd3;
    stepClk();
    inData4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    inMode4 = 2'b11; inTag4 = 4'd4;
    stepClk();
    inValid4 = 1'b0;
    @(negedge clk);
    nVec++;
    if (busy4 !== 1'b1 || outValid4 !== 1'b1 || modeErr4 !== 1'b1 || inReady4 !== 1'b0) begin
      nErr++;
      $display("FAIL mid_full busy=%b valid=%b err=%b in_ready=%b, expected 1 1 1 0",
               busy4, outValid4, modeErr4, inReady4);
    end
    #2 reset = 1'b1;
    #1;
    nVec++;
    if (outValid4 !== 1'b0 || busy4 !== 1'b0 || modeErr4 !== 1'b0 || outData4 !== '0) begin
      nErr++;
      $display("FAIL mid_async valid=%b busy=%b err=%b data=%h, expected 0 0 0 0",
               outValid4, busy4, modeErr4, outData4);
    end
    q4.delete();
    #1 reset = 1'b0;
    stepClk();
    outReady4 = 1'b1;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    inValid4 = 1'b1; inData4 = d; inMode4 = 2'b10; inTag4 = 4'd6;
    m = shiftModel(4, 2'b10, {d, 128'b0});
    e4.d = m[0:127]; e4.t = 4'd6; q4.push_back(e4);
    stepClk();
    inValid4 = 1'b0;
    @(negedge clk);
    nVec++;
    if (outValid4 !== 1'b0) begin
      nErr++;
      $display("FAIL mid_restart_early out_valid=%b, expected 0", outValid4);
    end
    stepClk();
    @(negedge clk);
    nVec++;
    if (outValid4 !== 1'b1 || outTag4 !== 4'd6) begin
      nErr++;
      $display("FAIL mid_restart out_valid=%b tag=%0d, expected 1 tag=6", outValid4, outTag4);
    end
    stepClk();
    stepClk();
    nVec++;
    if (q4.size() != 0) begin
      nErr++;
      $display("FAIL mid_pending %0d entries left, expected 0", q4.size());
    end
  endtask

  initial begin
    test_reset();
    test_inverse();
    test_back_to_back();
    test_nb8_forward();
    test_backpressure();
    test_reserved_mode();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
